top_tx: RTL and testbench

//  UART transmit top: baud-tick generator + 9-bit serialiser in one block.

---
 rtl/top_tx.sv | 140 ++++++++++++++
 tb/tb_top_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/top_tx.sv
// UART transmitter: free-running baud tick generator plus a start/data/stop
// serialiser. A host parallel-loads a word into a holding register; the word
// goes out LSB first, framed by a low start bit and a high stop bit.
//
// Handshake: TX_load is a level-sensitive strobe with no ready. While the
// transmitter is IDLE every cycle with TX_load=1 copies TX into the holding
// register and marks it pending, so the last value wins. Outside IDLE,
// TX_load is ignored. A pending word is launched on the next baud tick that
// arrives while the transmitter is IDLE.
module top_tx #(
  parameter int BAUD_DIV  = 5208,
  parameter int DATA_BITS = 9
) (
  input  logic                 clk,
  input  logic                 reset_n,    // active-high asynchronous reset
  input  logic                 startBTNC,
  input  logic                 TX_load,
  input  logic [DATA_BITS-1:0] TX,
  output logic                 TX_out,
  output logic                 CountSig,
  output logic [1:0]           dbg_state
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 tick_q, tick_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 pend_q, pend_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 txo_q, txo_d;
  logic                 run;

  // Baud counter: runs while enabled or while a frame is on the wire. The
  // tick flop is loaded with the decode of the next count so CountSig is high
  // exactly while the counter sits at its last value.
  always_comb begin
    run    = startBTNC || (state_q != S_IDLE);
    cnt_d  = '0;
    if (run && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
    tick_d = (cnt_d == CNT_LAST);
  end

  // Next-state, shifter, holding register and registered line level.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pend_d  = pend_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    txo_d   = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tick_q && pend_q) begin
          state_d = S_START;
          shift_d = hold_q;
          pend_d  = 1'b0;
        end
      end
      S_START: begin
        if (tick_q) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (tick_q) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_STOP: begin
        if (tick_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A load on the same edge a frame launches refills the holding register
    // for the following frame; the launching frame already took the old word.
    if (TX_load && (state_q == S_IDLE)) begin
      hold_d = TX;
      pend_d = 1'b1;
    end

    case (state_d)
      S_START: txo_d = 1'b0;
      S_DATA:  txo_d = shift_d[0];
      default: txo_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame and drops pending.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      hold_q  <= '0;
      pend_q  <= 1'b0;
      shift_q <= '0;
      idx_q   <= '0;
      txo_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      txo_q   <= txo_d;
    end
  end

  assign TX_out    = txo_q;
  assign CountSig  = tick_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_top_tx.sv
// Bench for top_tx with a short baud divisor. A frame-level reference model
// tracks the tick schedule and which word is on the wire; every accepted
// frame pushes its word into exp_q, and a serial-line decoder pops and
// compares each received frame. Line level and CountSig are also compared
// against the model every cycle.
module tb_top_tx;
  localparam int BD = 4;
  localparam int DB = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn;
  logic          ld;
  logic [DB-1:0] tx;
  logic          tx_out;
  logic          cnt_sig;
  logic [1:0]    dbg_state;

  int n_vec  = 0;
  int n_fail = 0;
  logic [DB-1:0] exp_q[$];

  // reference model state
  int            m_cnt;
  int            m_bit;     // -1 idle, 0 start, 1..DB data, DB+1 stop
  logic          m_pend;
  logic [DB-1:0] m_hold;
  logic [DB-1:0] m_word;
  logic          m_line;
  logic          m_tick;

  // clock
  always #5 clk = ~clk;

  top_tx #(.BAUD_DIV(BD), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .reset_n   (rst),
    .startBTNC (btn),
    .TX_load   (ld),
    .TX        (tx),
    .TX_out    (tx_out),
    .CountSig  (cnt_sig),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // reference model: advances on each rising edge from the inputs then held
  initial begin
    int  tick;
    bit  idle;
    m_cnt = 0; m_bit = -1; m_pend = 1'b0; m_hold = '0; m_word = '0;
    m_line = 1'b1; m_tick = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        if (m_bit >= 0 && m_bit <= DB) void'(exp_q.pop_back());
        m_cnt = 0; m_bit = -1; m_pend = 1'b0; m_hold = '0;
      end else begin
        tick = (m_cnt == BD - 1);
        idle = (m_bit < 0);
        if (tick) begin
          if (idle) begin
            if (m_pend) begin
              m_bit  = 0;
              m_word = m_hold;
              m_pend = 1'b0;
              exp_q.push_back(m_hold);
            end
          end else begin
            m_bit++;
            if (m_bit == DB + 2) m_bit = -1;
          end
        end
        if (ld && idle) begin
          m_hold = tx;
          m_pend = 1'b1;
        end
        if (btn || !idle) m_cnt = (m_cnt == BD - 1) ? 0 : m_cnt + 1;
        else              m_cnt = 0;
      end
      m_tick = (m_cnt == BD - 1);
      if (m_bit < 0)        m_line = 1'b1;
      else if (m_bit == 0)  m_line = 1'b0;
      else if (m_bit <= DB) m_line = m_word[m_bit-1];
      else                  m_line = 1'b1;
    end
  end

  // monitor: per-cycle line/tick compare plus serial frame decoder
  initial begin
    int            c = -1;
    int            b;
    logic          prev = 1'b1;
    logic [DB-1:0] w = '0;
    forever begin
      @(posedge clk);
      #1;
      check("tx_out", {{(DB-1){1'b0}}, tx_out}, {{(DB-1){1'b0}}, m_line});
      check("count_sig", {{(DB-1){1'b0}}, cnt_sig}, {{(DB-1){1'b0}}, m_tick});
      if (rst) begin
        c = -1;
        prev = 1'b1;
      end else if (c < 0) begin
        if (prev && !tx_out) c = 0;
        prev = tx_out;
      end else begin
        c++;
      end
      if (!rst && c >= 0 && (c % BD) == BD / 2) begin
        b = c / BD;
        if (b == 0) begin
          check("start_bit", {{(DB-1){1'b0}}, tx_out}, '0);
        end else if (b <= DB) begin
          w[b-1] = tx_out;
        end else begin
          check("stop_bit", {{(DB-1){1'b0}}, tx_out}, {{(DB-1){1'b0}}, 1'b1});
          if (exp_q.size() == 0) fail_now("frame_unexpected");
          else                   check("frame_word", w, exp_q.pop_front());
          c = -1;
          prev = 1'b1;
        end
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_word(input logic [DB-1:0] w, input int n);
    @(negedge clk);
    ld = 1'b1;
    tx = w;
    repeat (n) @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic wait_busy(input int budget);
    int k = 0;
    while (m_bit < 0 && k < budget) begin @(negedge clk); k++; end
    if (m_bit < 0) fail_now("timeout_frame_start");
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (m_bit >= 0 && k < budget) begin @(negedge clk); k++; end
    if (m_bit >= 0) fail_now("timeout_frame_end");
  endtask

  task automatic wait_bit(input int bit_no, input int budget);
    int k = 0;
    while (m_bit != bit_no && k < budget) begin @(negedge clk); k++; end
    if (m_bit != bit_no) fail_now("timeout_bit");
  endtask

  // stimulus
  initial begin
    rst = 1'b1; btn = 1'b0; ld = 1'b0; tx = '0;
    #50;
    check("reset_tx_out", {{(DB-1){1'b0}}, tx_out}, {{(DB-1){1'b0}}, 1'b1});
    check("reset_count_sig", {{(DB-1){1'b0}}, cnt_sig}, '0);
    @(negedge clk);
    rst = 1'b0;
    cyc(10);                       // generator must stay quiet with btn=0

    btn = 1'b1;
    cyc(20);                       // ticks only, line idle

    load_word(9'h155, 1);          // alternating pattern
    wait_busy(10); wait_idle(60); cyc(8);

    load_word(9'h1FF, 1);          // back-to-back: 1FF then 000
    wait_busy(10);
    @(negedge clk); ld = 1'b1; tx = 9'h000;
    wait_idle(60);
    @(negedge clk); ld = 1'b0;
    wait_busy(10); wait_idle(60); cyc(6);

    load_word(9'h155, 1);          // load during a frame is ignored
    wait_busy(10);
    @(negedge clk); ld = 1'b1; tx = 9'h0AA;
    cyc(20);
    ld = 1'b0;
    wait_idle(60); cyc(8);

    load_word(9'(($urandom_range(0, 511))), 1);   // enable dropped mid-frame
    wait_busy(10);
    cyc(10);
    btn = 1'b0;
    wait_idle(60); cyc(10);
    load_word(9'(($urandom_range(0, 511))), 1);   // stays pending while disabled
    cyc(20);
    btn = 1'b1;
    wait_busy(10); wait_idle(60);

    for (int i = 0; i < 12; i++) begin
      btn = ($urandom_range(0, 4) != 0);
      load_word(9'(($urandom_range(0, 511))), $urandom_range(1, 3));
      cyc($urandom_range(0, 50));
    end
    btn = 1'b1;
    wait_idle(100); cyc(10);
    wait_idle(100); cyc(10);

    load_word(9'h0F3, 1);          // reset during data bit 3
    wait_bit(4, 40);
    rst = 1'b1;
    #1;
    check("reset_mid_tx_out", {{(DB-1){1'b0}}, tx_out}, {{(DB-1){1'b0}}, 1'b1});
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cyc(40);

    check("queue_empty", DB'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
